// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues one word-aligned request at a time to an
// instruction memory, pushes each returned word together with its address into
// a small FIFO, and presents the FIFO head to decode. A redirect flushes the
// FIFO and moves the fetch PC. An all-zero instruction word stops fetching
// until the next redirect or reset.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rst_           : synchronous reset, active high
//   ena_pc         : fetch enable, gates the start of new requests only
//   imem_req       : request outstanding to instruction memory
//   imem_addr      : word-aligned request address, held until imem_ack
//   imem_ack       : memory accepts the request; imem_rdata valid this cycle
//   imem_rdata     : returned instruction word
//   redirect_valid : one-cycle redirect pulse from execute
//   redirect_pc    : redirect target, bits [1:0] ignored
//   inst           : instruction at the FIFO head
//   inst_pc        : address of inst
//   inst_valid     : FIFO head valid
//   inst_ready     : decode consumes the head when inst_valid is also high
//   halted         : fetch stopped on an all-zero word
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2   // 2 or 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        ena_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);

  localparam int unsigned      PTR_W      = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(BUF_DEPTH);
  localparam logic [31:0]      START_PC   = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;          // next address to fetch
  logic [31:0]      addr_q, addr_d;      // address of the outstanding request
  logic             discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [BUF_DEPTH-1:0][31:0] entry_data;
  logic [BUF_DEPTH-1:0][31:0] entry_pc;

  logic ack_fire;
  logic push;
  logic pop;
  logic buf_full;

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_fire = (state_q == S_WAIT) && imem_ack;
    pop      = (count_q != '0) && inst_ready;
    buf_full = (count_q == FULL_COUNT);
    // Data returned for a request that was overtaken by a redirect (earlier
    // or in this very cycle) never enters the buffer and is never tested for
    // the halt pattern.
    push     = ack_fire && !discard_q && !redirect_valid && (imem_rdata != 32'h0);

    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    unique case (state_q)
      S_IDLE: begin
        // Occupancy is checked before the request starts and only one
        // request can be in flight, so the eventual push always has room.
        if (ena_pc && !buf_full) begin
          state_d = S_WAIT;
          addr_d  = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !redirect_valid) begin
            if (imem_rdata == 32'h0) begin
              state_d = S_HALT;
            end else begin
              pc_d = addr_q + 32'd4;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Redirect overrides everything above. An in-flight request cannot be
    // withdrawn, so it stays on the bus and its data is marked for discard.
    // From IDLE the new request starts one cycle later, from the new PC.
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = {redirect_pc[31:2], 2'b00};
      if ((state_q == S_WAIT) && !imem_ack) begin
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      addr_q    <= START_PC;
      discard_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer storage, one register pair per entry
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);

      logic [31:0] data_q, data_d;
      logic [31:0] epc_q, epc_d;

      always_comb begin
        data_d = data_q;
        epc_d  = epc_q;
        if (push && (wr_ptr_q == IDX)) begin
          data_d = imem_rdata;
          epc_d  = addr_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst_) begin
          data_q <= '0;
          epc_q  <= '0;
        end else begin
          data_q <= data_d;
          epc_q  <= epc_d;
        end
      end

      assign entry_data[gi] = data_q;
      assign entry_pc[gi]   = epc_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers; stale entries are masked to zero.
  // ---------------------------------------------------------------------------
  assign imem_req   = (state_q == S_WAIT);
  assign imem_addr  = addr_q;
  assign halted     = (state_q == S_HALT);
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? entry_data[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? entry_pc[rd_ptr_q]   : 32'h0;

endmodule
